stoch_signed_pool_mode: RTL and testbench

Parametrised signed stochastic pooling layer with a runtime-selectable mode: windowed maximum or windowed average over bipolar (p/m) bitstream pairs. It generalises the fixed max-pool stage with internal per-input tracking counters, a stochastic average path, a warm-up gate, and restart on mode change. It sits between stochastic conv/activation stages in the NNlib bitstream datapath, and its output ordering matches the feature-map ordering of those neighbouring stages.

---
 rtl/stoch_signed_pool_mode.sv | 150 +++++++++++++++
 tb/tb_stoch_signed_pool_mode.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/stoch_signed_pool_mode.sv
// Signed bipolar stochastic pooling: per-window max (saturating tracking counters)
// or exact deterministic average (residue accumulator), with restart and warm-up gating.
module stoch_signed_pool_mode #(
  parameter int IM_HEIGHT    = 12,
  parameter int IM_WIDTH     = 12,
  parameter int CHANNELS     = 3,
  parameter int KERNEL_H     = 3,
  parameter int KERNEL_W     = 3,
  parameter int PAD_H        = 0,
  parameter int PAD_W        = 0,
  parameter int STRIDE_H     = 1,
  parameter int STRIDE_W     = 1,
  parameter int COUNTER_SIZE = 8,
  parameter int WARMUP       = 16,
  localparam int OUT_H       = (IM_HEIGHT + 2 * PAD_H - KERNEL_H) / STRIDE_H + 1,
  localparam int OUT_W       = (IM_WIDTH + 2 * PAD_W - KERNEL_W) / STRIDE_W + 1,
  localparam int N_IN        = IM_HEIGHT * IM_WIDTH * CHANNELS,
  localparam int N_OUT       = OUT_H * OUT_W * CHANNELS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic [N_IN-1:0]  x_p,
  input  logic [N_IN-1:0]  x_m,
  output logic [N_OUT-1:0] y_p,
  output logic [N_OUT-1:0] y_m,
  output logic             warm
);

  localparam int K   = KERNEL_H * KERNEL_W;
  localparam int CW  = COUNTER_SIZE;
  localparam int AW  = $clog2(K) + 2;
  localparam int WCW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

  localparam logic signed [CW-1:0] C_ONE = CW'(1);
  localparam logic signed [CW-1:0] C_MAX = {1'b0, {(CW - 1){1'b1}}};
  localparam logic signed [CW-1:0] C_MIN = {1'b1, {(CW - 1){1'b0}}};
  localparam logic signed [AW-1:0] A_ONE = AW'(1);
  localparam logic signed [AW-1:0] K_S   = AW'(K);

  logic           mode_q;
  logic           restart;
  logic           gate;
  logic [WCW-1:0] wcnt;
  logic [WCW-1:0] wcnt_nx;

  // A mode flip is treated exactly like a reset pulse so the new mode starts clean.
  assign restart = rst || (mode != mode_q);

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    wcnt_nx = wcnt;
    if (wcnt != WCW'(WARMUP)) wcnt_nx = wcnt + 1'b1;
  end

  // Gate uses the post-edge count, so the first live output lands on the edge warm rises.
  assign gate = !restart && (wcnt_nx == WCW'(WARMUP));

  // NOTE: sequential state uses non-blocking assignments only, so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    mode_q <= mode;
    warm   <= gate;
    if (restart) wcnt <= '0;
    else         wcnt <= wcnt_nx;
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    for (genvar ow = 0; ow < OUT_W; ow++) begin : g_ow
      for (genvar oh = 0; oh < OUT_H; oh++) begin : g_oh
        localparam int O = c * OUT_H * OUT_W + ow * OUT_H + oh;

        logic [K-1:0]          wp;
        logic [K-1:0]          wm;
        logic signed [CW-1:0]  cnt [K];
        logic signed [CW-1:0]  best;
        logic signed [AW-1:0]  acc;
        logic signed [AW-1:0]  acc_nx;
        logic signed [AW-1:0]  sum;
        logic signed [AW-1:0]  t;
        logic                  sel_p, sel_m, avg_p, avg_m;
        logic                  yp_q, ym_q;

        for (genvar kw = 0; kw < KERNEL_W; kw++) begin : g_kw
          for (genvar kh = 0; kh < KERNEL_H; kh++) begin : g_kh
            localparam int ROW = oh * STRIDE_H + kh - PAD_H;
            localparam int COL = ow * STRIDE_W + kw - PAD_W;
            if (ROW >= 0 && ROW < IM_HEIGHT && COL >= 0 && COL < IM_WIDTH) begin : g_in
              assign wp[kw * KERNEL_H + kh] = x_p[c * IM_HEIGHT * IM_WIDTH + COL * IM_HEIGHT + ROW];
              assign wm[kw * KERNEL_H + kh] = x_m[c * IM_HEIGHT * IM_WIDTH + COL * IM_HEIGHT + ROW];
            end else begin : g_pad
              assign wp[kw * KERNEL_H + kh] = 1'b0;
              assign wm[kw * KERNEL_H + kh] = 1'b0;
            end
          end
        end

        // Strict '>' keeps the lowest index on ties.
        always_comb begin
          best  = cnt[0];
          sel_p = wp[0];
          sel_m = wm[0];
          for (int i = 1; i < K; i++) begin
            if (cnt[i] > best) begin
              best  = cnt[i];
              sel_p = wp[i];
              sel_m = wm[i];
            end
          end
        end

        // Residue accumulator: emits one +/-1 per K units of summed value, so density is exact.
        always_comb begin
          sum = '0;
          for (int i = 0; i < K; i++) begin
            if (wp[i]) sum = sum + A_ONE;
            if (wm[i]) sum = sum - A_ONE;
          end
          t      = acc + sum;
          avg_p  = 1'b0;
          avg_m  = 1'b0;
          acc_nx = t;
          if (t >= K_S) begin
            avg_p  = 1'b1;
            acc_nx = t - K_S;
          end else if (t <= -K_S) begin
            avg_m  = 1'b1;
            acc_nx = t + K_S;
          end
        end

        // NOTE: the counter array is cleared explicitly because restart is a functional event, not just power-up.
        always_ff @(posedge clk) begin
          for (int i = 0; i < K; i++) begin
            if (restart || mode)                          cnt[i] <= '0;
            else if (wp[i] && !wm[i] && cnt[i] != C_MAX)  cnt[i] <= cnt[i] + C_ONE;
            else if (wm[i] && !wp[i] && cnt[i] != C_MIN)  cnt[i] <= cnt[i] - C_ONE;
          end
          if (restart || !mode) acc <= '0;
          else                  acc <= acc_nx;
          yp_q <= gate && (mode ? avg_p : sel_p);
          ym_q <= gate && (mode ? avg_m : sel_m);
        end

        assign y_p[O] = yp_q;
        assign y_m[O] = ym_q;
      end
    end
  end

endmodule

// File: tb/tb_stoch_signed_pool_mode.sv
// Directed bench for stoch_signed_pool_mode: table-driven max/avg/mode-change vectors
// plus hand sequences for saturation, WARMUP=0 and padded corner windows.
module tb_stoch_signed_pool_mode;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Main config: 4x4, 1 ch, 2x2 kernel, stride 2 -> 2x2 output, WARMUP=4
  logic        rst_a, mode_a;
  logic [15:0] xp_a, xm_a;
  logic [3:0]  yp_a, ym_a;
  logic        warm_a;

  // Same geometry, WARMUP=0
  logic        rst_z, mode_z;
  logic [15:0] xp_z, xm_z;
  logic [3:0]  yp_z, ym_z;
  logic        warm_z;

  // Padded: 3x3, pad 1, 2x2 kernel, stride 1 -> 4x4 output
  logic        rst_p, mode_p;
  logic [8:0]  xp_p, xm_p;
  logic [15:0] yp_p, ym_p;
  logic        warm_p;

  stoch_signed_pool_mode #(
    .IM_HEIGHT(4), .IM_WIDTH(4), .CHANNELS(1), .KERNEL_H(2), .KERNEL_W(2),
    .PAD_H(0), .PAD_W(0), .STRIDE_H(2), .STRIDE_W(2), .COUNTER_SIZE(4), .WARMUP(4)
  ) dut_a (
    .clk(clk), .rst(rst_a), .mode(mode_a), .x_p(xp_a), .x_m(xm_a),
    .y_p(yp_a), .y_m(ym_a), .warm(warm_a)
  );

  stoch_signed_pool_mode #(
    .IM_HEIGHT(4), .IM_WIDTH(4), .CHANNELS(1), .KERNEL_H(2), .KERNEL_W(2),
    .PAD_H(0), .PAD_W(0), .STRIDE_H(2), .STRIDE_W(2), .COUNTER_SIZE(4), .WARMUP(0)
  ) dut_z (
    .clk(clk), .rst(rst_z), .mode(mode_z), .x_p(xp_z), .x_m(xm_z),
    .y_p(yp_z), .y_m(ym_z), .warm(warm_z)
  );

  stoch_signed_pool_mode #(
    .IM_HEIGHT(3), .IM_WIDTH(3), .CHANNELS(1), .KERNEL_H(2), .KERNEL_W(2),
    .PAD_H(1), .PAD_W(1), .STRIDE_H(1), .STRIDE_W(1), .COUNTER_SIZE(4), .WARMUP(4)
  ) dut_p (
    .clk(clk), .rst(rst_p), .mode(mode_p), .x_p(xp_p), .x_m(xm_p),
    .y_p(yp_p), .y_m(ym_p), .warm(warm_p)
  );

  typedef struct {
    logic        rst;
    logic        mode;
    logic [15:0] xp;
    logic [15:0] xm;
    logic [3:0]  yp;
    logic [3:0]  ym;
    logic        warm;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic m, input logic [15:0] xp, input logic [15:0] xm,
                     input logic [3:0] yp, input logic [3:0] ym, input logic w, input int n);
    vec_t v;
    v.rst = r; v.mode = m; v.xp = xp; v.xm = xm; v.yp = yp; v.ym = ym; v.warm = w;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_a = 1'b1; mode_a = 1'b0; xp_a = '0; xm_a = '0;
    rst_z = 1'b1; mode_z = 1'b0; xp_z = '0; xm_z = '0;
    rst_p = 1'b1; mode_p = 1'b1; xp_p = '0; xm_p = '0;

    // Window 0 of dut_a: element 0 -> idx 0, 1 -> idx 1, 2 -> idx 4, 3 -> idx 5.
    // Reset 3 cycles, warm-up with all +1 (max mode, ties -> element 0 -> y_p=1 everywhere)
    add(1, 0, 16'hFFFF, 16'h0000, 4'h0, 4'h0, 0, 3);
    add(0, 0, 16'hFFFF, 16'h0000, 4'h0, 4'h0, 0, 3);
    add(0, 0, 16'hFFFF, 16'h0000, 4'hF, 4'h0, 1, 3);
    // Single-cycle reset, then element 2 = +1, elements 0,1,3 = -1
    add(1, 0, 16'h0010, 16'h0023, 4'h0, 4'h0, 0, 1);
    add(0, 0, 16'h0010, 16'h0023, 4'h0, 4'h0, 0, 3);
    add(0, 0, 16'h0010, 16'h0023, 4'h1, 4'h0, 1, 3);
    // Average: two +1, two 0 -> pulse every 2nd cycle (even edges after reset)
    add(1, 1, 16'h0003, 16'h0000, 4'h0, 4'h0, 0, 1);
    add(0, 1, 16'h0003, 16'h0000, 4'h0, 4'h0, 0, 3);
    add(0, 1, 16'h0003, 16'h0000, 4'h1, 4'h0, 1, 1);
    add(0, 1, 16'h0003, 16'h0000, 4'h0, 4'h0, 1, 1);
    add(0, 1, 16'h0003, 16'h0000, 4'h1, 4'h0, 1, 1);
    add(0, 1, 16'h0003, 16'h0000, 4'h0, 4'h0, 1, 1);
    // All four -1: residue 2 absorbs first cycle, then y_m every cycle
    add(0, 1, 16'h0000, 16'h0033, 4'h0, 4'h0, 1, 1);
    add(0, 1, 16'h0000, 16'h0033, 4'h0, 4'h1, 1, 3);
    // Toggle to max, then back to avg during warm-up: the count restarts at the second toggle
    add(0, 0, 16'hFFFF, 16'h0000, 4'h0, 4'h0, 0, 2);
    add(0, 1, 16'h0003, 16'h0000, 4'h0, 4'h0, 0, 4);
    add(0, 1, 16'h0003, 16'h0000, 4'h1, 4'h0, 1, 1);
    add(0, 1, 16'h0003, 16'h0000, 4'h0, 4'h0, 1, 1);
    add(0, 1, 16'h0003, 16'h0000, 4'h1, 4'h0, 1, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      rst_a = tbl[i].rst; mode_a = tbl[i].mode; xp_a = tbl[i].xp; xm_a = tbl[i].xm;
      step();
      check($sformatf("row%0d y_p", i), 32'(yp_a), 32'(tbl[i].yp));
      check($sformatf("row%0d y_m", i), 32'(ym_a), 32'(tbl[i].ym));
      check($sformatf("row%0d warm", i), 32'(warm_a), 32'(tbl[i].warm));
    end

    // Saturation: c_0 climbs to 7 and holds (a wrapping counter would switch one cycle early)
    rst_a = 1'b1; mode_a = 1'b0; xp_a = 16'h0001; xm_a = 16'h0000;
    step();
    check("sat reset y_p", 32'(yp_a), 32'h0);
    rst_a = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      check($sformatf("sat climb%0d y_p", k), 32'(yp_a), (k >= 4) ? 32'h1 : 32'h0);
      check($sformatf("sat climb%0d y_m", k), 32'(ym_a), 32'h0);
    end
    xp_a = 16'h0002; xm_a = 16'h0001;
    for (int k = 0; k < 8; k++) begin
      step();
      check($sformatf("sat switch%0d y_p", k), 32'(yp_a), (k >= 4) ? 32'h1 : 32'h0);
      check($sformatf("sat switch%0d y_m", k), 32'(ym_a), (k < 4) ? 32'h1 : 32'h0);
    end

    // WARMUP=0: live from first edge after reset; p=m=1 on element 0 passes both bits
    xp_z = 16'h0001; xm_z = 16'h0001;
    step();
    check("w0 reset warm", 32'(warm_z), 32'h0);
    check("w0 reset y_p", 32'(yp_z), 32'h0);
    rst_z = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      check($sformatf("w0 cyc%0d warm", k), 32'(warm_z), 32'h1);
      check($sformatf("w0 cyc%0d y_p", k), 32'(yp_z), 32'h1);
      check($sformatf("w0 cyc%0d y_m", k), 32'(ym_z), 32'h1);
    end

    // Padding: input (0,0) is element 3 of window (0,0), element 2 of (1,0),
    // element 1 of (0,1), element 0 of (1,1) -> outputs 0,1,4,5 pulse once per 4 cycles
    xp_p = 9'h001; xm_p = 9'h000;
    step();
    check("pad reset y_p", 32'(yp_p), 32'h0);
    rst_p = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      step();
      check($sformatf("pad cyc%0d y_p", k), 32'(yp_p), (k % 4 == 0) ? 32'h0033 : 32'h0);
      check($sformatf("pad cyc%0d y_m", k), 32'(ym_p), 32'h0);
      check($sformatf("pad cyc%0d warm", k), 32'(warm_p), (k >= 4) ? 32'h1 : 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
